// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 1-cycle-latency memory port between fetch and load/store,
// with load/store priority bounded by a fetch starvation counter.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_n_bytes,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_n_bytes,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_addr_err
);
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS, OWN_LS_BAD} owner_e;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  owner_e     owner_q, owner_d;
  logic [3:0] starve_q, starve_d;
  logic       ls_we_q, ls_we_d;
  logic       if_win, ls_win, ls_ok, ls_issue;
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= OWN_NONE;
      starve_q <= 4'd0;
      ls_we_q  <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
      ls_we_q  <= ls_we_d;
    end
  end
  always_comb begin
    ls_ok = (ls_n_bytes == 2'd0) || (ls_n_bytes == 2'd1 && !ls_addr[0]) ||
            (ls_n_bytes == 2'd2 && ls_addr[1:0] == 2'b00);
    if_win = !rst && if_req && (!ls_req || starve_q >= LIMIT);
    ls_win = !rst && ls_req && !if_win;
    ls_issue = ls_win && ls_ok;
    if_gnt = if_win;
    ls_gnt = ls_win;
    mem_req = if_win || ls_issue;
    mem_we = ls_issue && ls_we;
    mem_n_bytes = if_win ? 2'd2 : ls_issue ? ls_n_bytes : 2'd0;
    mem_addr = if_win ? if_addr : ls_issue ? ls_addr : '0;
    mem_wdata = ls_issue ? ls_wdata : '0;
    owner_d = if_win ? OWN_IF : ls_win ? (ls_ok ? OWN_LS : OWN_LS_BAD) : OWN_NONE;
    ls_we_d = ls_issue && ls_we;
    starve_d = (!if_req || if_win) ? 4'd0 :
               (ls_win && starve_q != 4'hF) ? starve_q + 4'd1 : starve_q;
  end
  // rst masks responses combinationally so a response in flight at reset is dropped
  always_comb begin
    if_rvalid = !rst && owner_q == OWN_IF;
    if_err = if_rvalid && mem_addr_err;
    if_rdata = (if_rvalid && !mem_addr_err) ? mem_rdata : '0;
    ls_rvalid = !rst && (owner_q == OWN_LS || owner_q == OWN_LS_BAD);
    ls_err = ls_rvalid && (owner_q == OWN_LS_BAD || mem_addr_err);
    ls_rdata = (ls_rvalid && owner_q == OWN_LS && !ls_we_q && !mem_addr_err) ? mem_rdata : '0;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios against a 1-cycle-latency memory model.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid, ls_err;
  logic [1:0]  ls_n_bytes;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        mem_req, mem_we, mem_addr_err;
  logic [1:0]  mem_n_bytes;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:16383];
  int pass_cnt = 0;
  int total_cnt = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_n_bytes(ls_n_bytes), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_n_bytes(mem_n_bytes), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_addr_err(mem_addr_err)
  );

  always #5 clk = ~clk;

  // 64 KiB word memory; addresses at or above 0x10000 raise an address error
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) mem[mem_addr[15:2]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[15:2]];
      mem_addr_err <= mem_addr >= 32'h0001_0000;
    end else begin
      mem_rdata <= 32'hA5A5_A5A5;
      mem_addr_err <= 1'b0;
    end
  end

  task automatic idle();
    if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_n_bytes = 0; ls_addr = 0; ls_wdata = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1; if_req = 1; if_addr = 32'h100; ls_req = 1; ls_addr = 32'h200; ls_n_bytes = 2;
    @(negedge clk); #1;
    total_cnt++; if (if_gnt !== 1'b0) $display("FAIL reset_if_gnt: got %b expected 0", if_gnt); else pass_cnt++;
    total_cnt++; if (ls_gnt !== 1'b0) $display("FAIL reset_ls_gnt: got %b expected 0", ls_gnt); else pass_cnt++;
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b expected 0", mem_req); else pass_cnt++;
    total_cnt++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); else pass_cnt++;
    total_cnt++; if ({if_rvalid, ls_rvalid, if_err, ls_err} !== 4'b0) $display("FAIL reset_resp: got %b expected 0000", {if_rvalid, ls_rvalid, if_err, ls_err}); else pass_cnt++;
    total_cnt++; if ({if_rdata, ls_rdata} !== 64'h0) $display("FAIL reset_rdata: got %h expected 0", {if_rdata, ls_rdata}); else pass_cnt++;
    @(negedge clk); rst = 0; idle();
  endtask

  task automatic test_fetch();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle(); if_req = (i < 3); if_addr = (i < 3) ? 32'h100 : 32'h0;
      #1;
      total_cnt++; if (if_gnt !== (i < 3)) $display("FAIL fetch_gnt[%0d]: got %b expected %b", i, if_gnt, i < 3); else pass_cnt++;
      total_cnt++; if (mem_addr !== ((i < 3) ? 32'h100 : 32'h0)) $display("FAIL fetch_mem_addr[%0d]: got %h", i, mem_addr); else pass_cnt++;
      total_cnt++; if (mem_n_bytes !== ((i < 3) ? 2'd2 : 2'd0)) $display("FAIL fetch_n_bytes[%0d]: got %0d", i, mem_n_bytes); else pass_cnt++;
      total_cnt++; if (if_rvalid !== (i > 0)) $display("FAIL fetch_rvalid[%0d]: got %b expected %b", i, if_rvalid, i > 0); else pass_cnt++;
      total_cnt++; if (if_rdata !== ((i > 0) ? 32'h1234_5678 : 32'h0)) $display("FAIL fetch_rdata[%0d]: got %h", i, if_rdata); else pass_cnt++;
    end
  endtask

  task automatic test_contention();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk); idle();
      if (i < 10) begin if_req = 1; if_addr = 32'h100; ls_req = 1; ls_n_bytes = 2; ls_addr = 32'h200; end
      #1;
      total_cnt++; if (ls_gnt !== (i < 10 && i % 5 != 4)) $display("FAIL cont_ls_gnt[%0d]: got %b", i, ls_gnt); else pass_cnt++;
      total_cnt++; if (if_gnt !== (i < 10 && i % 5 == 4)) $display("FAIL cont_if_gnt[%0d]: got %b", i, if_gnt); else pass_cnt++;
      if (i > 0) begin
        total_cnt++; if (if_rvalid !== ((i - 1) % 5 == 4)) $display("FAIL cont_if_rvalid[%0d]: got %b", i, if_rvalid); else pass_cnt++;
        total_cnt++; if (ls_rdata !== (((i - 1) % 5 != 4) ? 32'hCAFE_F00D : 32'h0)) $display("FAIL cont_ls_rdata[%0d]: got %h", i, ls_rdata); else pass_cnt++;
      end
    end
  endtask

  task automatic test_misaligned();
    logic [1:0]  nb [6] = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd1, 2'd2};
    logic [31:0] ad [6] = '{32'h202, 32'h203, 32'h200, 32'h203, 32'h202, 32'h200};
    logic        ok [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); idle(); ls_req = 1; ls_n_bytes = nb[i]; ls_addr = ad[i];
      #1;
      total_cnt++; if (ls_gnt !== 1'b1) $display("FAIL mis_gnt[%0d]: got %b expected 1", i, ls_gnt); else pass_cnt++;
      total_cnt++; if (mem_req !== ok[i]) $display("FAIL mis_mem_req[%0d]: got %b expected %b", i, mem_req, ok[i]); else pass_cnt++;
      @(negedge clk); idle(); #1;
      total_cnt++; if (ls_rvalid !== 1'b1) $display("FAIL mis_rvalid[%0d]: got %b expected 1", i, ls_rvalid); else pass_cnt++;
      total_cnt++; if (ls_err !== !ok[i]) $display("FAIL mis_err[%0d]: got %b expected %b", i, ls_err, !ok[i]); else pass_cnt++;
      total_cnt++; if (ls_rdata !== (ok[i] ? 32'hCAFE_F00D : 32'h0)) $display("FAIL mis_rdata[%0d]: got %h", i, ls_rdata); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); idle(); ls_req = 1; ls_we = 1; ls_n_bytes = 2; ls_addr = 32'h400; ls_wdata = 32'hDEAD_BEEF;
    #1;
    total_cnt++; if ({ls_gnt, mem_req, mem_we} !== 3'b111) $display("FAIL b2b_store_issue: got %b expected 111", {ls_gnt, mem_req, mem_we}); else pass_cnt++;
    total_cnt++; if (mem_wdata !== 32'hDEAD_BEEF) $display("FAIL b2b_wdata: got %h expected deadbeef", mem_wdata); else pass_cnt++;
    @(negedge clk); ls_we = 0; ls_wdata = 0;
    #1;
    total_cnt++; if ({ls_gnt, mem_req, mem_we} !== 3'b110) $display("FAIL b2b_load_issue: got %b expected 110", {ls_gnt, mem_req, mem_we}); else pass_cnt++;
    total_cnt++; if ({ls_rvalid, ls_err} !== 2'b10) $display("FAIL b2b_store_ack: got %b expected 10", {ls_rvalid, ls_err}); else pass_cnt++;
    total_cnt++; if (ls_rdata !== 32'h0) $display("FAIL b2b_store_rdata: got %h expected 0", ls_rdata); else pass_cnt++;
    @(negedge clk); idle(); #1;
    total_cnt++; if ({ls_rvalid, ls_err} !== 2'b10) $display("FAIL b2b_load_resp: got %b expected 10", {ls_rvalid, ls_err}); else pass_cnt++;
    total_cnt++; if (ls_rdata !== 32'hDEAD_BEEF) $display("FAIL b2b_load_rdata: got %h expected deadbeef", ls_rdata); else pass_cnt++;
  endtask

  task automatic test_addr_err();
    @(negedge clk); idle(); if_req = 1; if_addr = 32'h0001_0000;
    #1;
    total_cnt++; if (if_gnt !== 1'b1) $display("FAIL err_gnt: got %b expected 1", if_gnt); else pass_cnt++;
    @(negedge clk); idle(); #1;
    total_cnt++; if ({if_rvalid, if_err} !== 2'b11) $display("FAIL err_resp: got %b expected 11", {if_rvalid, if_err}); else pass_cnt++;
    total_cnt++; if (if_rdata !== 32'h0) $display("FAIL err_rdata: got %h expected 0", if_rdata); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); if_req = 1; if_addr = 32'h100; ls_req = 1; ls_n_bytes = 2; ls_addr = 32'h200;
      #1;
      total_cnt++; if (ls_gnt !== 1'b1) $display("FAIL rmid_pre_gnt[%0d]: got %b expected 1", i, ls_gnt); else pass_cnt++;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); rst = 1; #1;
      total_cnt++; if ({ls_rvalid, if_rvalid} !== 2'b00) $display("FAIL rmid_rvalid[%0d]: got %b expected 00", i, {ls_rvalid, if_rvalid}); else pass_cnt++;
      total_cnt++; if ({ls_gnt, if_gnt, mem_req} !== 3'b000) $display("FAIL rmid_gnt[%0d]: got %b expected 000", i, {ls_gnt, if_gnt, mem_req}); else pass_cnt++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); rst = 0; #1;
      total_cnt++; if ({ls_gnt, if_gnt} !== ((i == 4) ? 2'b01 : 2'b10)) $display("FAIL rmid_post_gnt[%0d]: got %b", i, {ls_gnt, if_gnt}); else pass_cnt++;
    end
    @(negedge clk); idle();
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    mem[0] = 32'hFFFF_FFFF;
    mem[32'h100 >> 2] = 32'h1234_5678;
    mem[32'h200 >> 2] = 32'hCAFE_F00D;
    mem_rdata = 0; mem_addr_err = 0;
    rst = 1; idle();
    test_reset();
    test_fetch();
    test_contention();
    test_misaligned();
    test_back_to_back();
    test_addr_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
